fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline: owns PC register, PC+4 adder, next-PC mux, IF/ID pipeline register.
//  Presents fetched instruction + PC+4 to ID, where the control unit decodes opcode/func and returns PCsrc.
//  Applies hazard-unit stalls; squashes the wrong-path instruction on taken branch/jump.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0000  instruction word injected on flush/reset (sll $0,$0,0)
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   synchronous, active-high reset
//  stall         in   1   hazard unit: hold PC and IF/ID (load-use)
//  PCsrc         in   2   from control unit: 0=PC+4, 1=branch target, 2=jump target, 3=reserved
//  branchAddr    in   32  branch target computed in ID
//  jumpAddr      in   32  jump target computed in ID
//  imemAddr      out  32  instruction memory address (= current PC)
//  imemData      in   32  instruction word, combinational read of imemAddr
//  pc            out  32  current PC register
//  ifid_instr    out  32  IF/ID instruction to decode/control unit
//  ifid_pc4      out  32  IF/ID PC+4
//  ifid_valid    out  1   1=real instruction, 0=bubble (reset/flush)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): pc<=RESET_PC; ifid_instr<=NOP_INSTR; ifid_pc4<=0; ifid_valid<=0; counters<=0.
//    Reset wins over stall/redirect; mid-stream reset drops in-flight instruction, no partial state kept.
//  - imemAddr = pc combinationally; pc4 = pc + 32'd4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
//  - Priority per cycle: rst > stall > redirect (PCsrc=1/2) > sequential.
//  - stall=1: pc and all IF/ID regs hold; PCsrc ignored (branch in ID is held and re-resolves next cycle).
//  - stall=0, PCsrc=1: pc<=branchAddr; IF/ID <= NOP_INSTR, pc4 0, valid 0 (flush wrong-path fetch).
//  - stall=0, PCsrc=2: pc<=jumpAddr; same flush.
//  - stall=0, PCsrc=0 or 3: pc<=pc4; ifid_instr<=imemData; ifid_pc4<=pc4; ifid_valid<=1.
//  - Latency: instruction at PC appears on ifid_instr 1 cycle after pc=PC with no stall.
//  - Taken branch/jump penalty exactly 1 bubble. Redirect target low 2 bits passed through unmodified.
//  - Back-to-back redirects: bubble in ID yields PCsrc=0 (NOP decodes as Rtype), so no spurious redirect.
// CONFIGURATION
//  FETCH_STATS_EN defined: extra out ports fetchCount/stallCount/flushCount (32 each), sync-reset to 0;
//    fetchCount++ on sequential advance, stallCount++ per stall cycle, flushCount++ per redirect; wrap at 2^32.
//  FETCH_STATS_EN undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Shared package mips_pkg: PCsrc encoding constants (PC_SEQ=0, PC_BR=1, PC_J=2), NOP_INSTR value, word width.
//  Sub-module if_id_reg: IF/ID register with hold (stall) and flush inputs, reused pattern for ID/EX.
//  Next-PC mux and adder stay inline in fetch_stage.
// TESTING
//  1 rst=1 two cycles then release, imem[i]=i+0x100 -> pc 0,4,8; ifid_instr 0x100,0x101 from cycle 2; valid 0 then 1.
//  2 stall=1 for 3 cycles at pc=8 -> pc, ifid_instr, ifid_pc4 constant; PCsrc=1 during stall ignored.
//  3 PCsrc=1, branchAddr=0x40 with stall=0 -> next pc=0x40, ifid_instr=0, valid=0; following cycle instr at 0x40.
//  4 PCsrc=2, jumpAddr=0x1000 -> pc=0x1000, one bubble; PCsrc=3 behaves as PC+4.
//  5 pc forced to 0xFFFF_FFFC via jump -> next sequential pc=0, ifid_pc4=0.
//  6 rst asserted while stall=1 and PCsrc=2 -> pc=RESET_PC, ifid_valid=0; with FETCH_STATS_EN counters read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: word width, PCsrc encoding, NOP word,
// and the IF/ID pipeline register payload.
package mips_pkg;

   localparam int WORD_W = 32;

   // PCsrc encoding returned by the control unit (3 is reserved, treated as sequential)
   localparam logic [1:0] PC_SEQ = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_J   = 2'd2;

   // sll $0,$0,0
   localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc4;
      logic              valid;
   } ifid_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold (stall) and flush (bubble insert).
// Reset and flush both load a bubble; hold has priority over flush.
module if_id_reg
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  hold,
   input  logic  flush,
   input  ifid_t d,
   output ifid_t q
);

   ifid_t q_d, q_q, bubble;

   // Next register contents: hold, then flush to a bubble, else load
   always_comb begin
      bubble.instr = NOP_INSTR;
      bubble.pc4   = '0;
      bubble.valid = 1'b0;
      q_d = q_q;
      if (!hold) begin
         if (flush) q_d = bubble;
         else       q_d = d;
      end
   end

   // Register with synchronous reset to a bubble
   always_ff @(posedge clk) begin
      if (rst) q_q <= bubble;
      else     q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, PC+4 adder, next-PC mux
// and the IF/ID register. A taken branch/jump costs exactly one bubble.
// Optional macro FETCH_STATS_EN adds fetch/stall/flush event counters.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic [1:0]        PCsrc,
   input  logic [WORD_W-1:0] branchAddr,
   input  logic [WORD_W-1:0] jumpAddr,
   output logic [WORD_W-1:0] imemAddr,
   input  logic [WORD_W-1:0] imemData,
   output logic [WORD_W-1:0] pc,
   output logic [WORD_W-1:0] ifid_instr,
   output logic [WORD_W-1:0] ifid_pc4,
   output logic              ifid_valid
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]       fetchCount,
   output logic [31:0]       stallCount,
   output logic [31:0]       flushCount
`endif
);

   logic [WORD_W-1:0] pc_d, pc_q, pc4;
   logic              redirect, advance;
   ifid_t             fetch_word, ifid;

   // Wraps modulo 2^32
   assign pc4      = pc_q + 32'd4;
   assign imemAddr = pc_q;
   assign pc       = pc_q;

   // Next-PC mux: stall holds and ignores PCsrc; reserved code 3 falls through to PC+4
   always_comb begin
      pc_d     = pc_q;
      redirect = 1'b0;
      advance  = 1'b0;
      if (!stall) begin
         case (PCsrc)
            PC_BR: begin
               pc_d     = branchAddr;
               redirect = 1'b1;
            end
            PC_J: begin
               pc_d     = jumpAddr;
               redirect = 1'b1;
            end
            default: begin
               pc_d    = pc4;
               advance = 1'b1;
            end
         endcase
      end
   end

   // PC register
   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= pc_d;
   end

   // Payload captured into IF/ID on a sequential advance
   always_comb begin
      fetch_word.instr = imemData;
      fetch_word.pc4   = pc4;
      fetch_word.valid = 1'b1;
   end

   if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
      .clk   (clk),
      .rst   (rst),
      .hold  (stall),
      .flush (redirect),
      .d     (fetch_word),
      .q     (ifid)
   );

   assign ifid_instr = ifid.instr;
   assign ifid_pc4   = ifid.pc4;
   assign ifid_valid = ifid.valid;

`ifdef FETCH_STATS_EN
   logic [31:0] fetch_cnt_d, fetch_cnt_q;
   logic [31:0] stall_cnt_d, stall_cnt_q;
   logic [31:0] flush_cnt_d, flush_cnt_q;

   // Event counters, free-running with natural wrap
   always_comb begin
      fetch_cnt_d = fetch_cnt_q + {31'd0, advance};
      stall_cnt_d = stall_cnt_q + {31'd0, stall};
      flush_cnt_d = flush_cnt_q + {31'd0, redirect};
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign fetchCount = fetch_cnt_q;
   assign stallCount = stall_cnt_q;
   assign flushCount = flush_cnt_q;
`endif

endmodule
